// File: rtl/ycr2_sched_pkg.sv
// Shared types and limits for the core memory-port scheduler.
package ycr2_sched_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_REQ   = 2'd1,
    SCH_BURST = 2'd2
  } sched_st_e;

  localparam int YCR2_SCHED_TREQ_MAX = 8;

endpackage

// File: rtl/ycr2_rr_pick.sv
// Combinational round-robin picker: the search starts one past 'last' and wraps,
// and the first set request wins.
module ycr2_rr_pick #(
  parameter int TREQ = 4,
  parameter int GW   = $clog2(TREQ)
) (
  input  logic [TREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   win,
  output logic            any
);

  int idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < TREQ; i++) begin
      idx = (int'(last) + 1 + i) % TREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/ycr2_mem_sched.sv
// Round-robin scheduler for the shared core memory port; the grant is held until lack.
// Optional watchdog release is enabled by defining YCR2_SCHED_WDT_EN.
module ycr2_mem_sched
  import ycr2_sched_pkg::*;
#(
  parameter  int TREQ  = 4,
  localparam int GW    = $clog2(TREQ),
  parameter  int WDT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TREQ-1:0] req,
  input  logic            req_ack,
  input  logic            lack,
  output logic [GW-1:0]   gnt,
  output logic            gnt_vld,
  output logic            busy,
  output logic            wdt_err,
  output sched_st_e       dbg_state
);

  // Handshake: the router forwards req[gnt] only while gnt_vld=1; req_ack marks an
  // accepted beat, lack marks the final beat and frees the port on that same cycle.

  sched_st_e       state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic            busy_q, busy_d;
  logic            wdt_err_q, wdt_err_d;
  logic [GW-1:0]   pick_win;
  logic            pick_any;
  logic            wdt_sat;
  logic            rearb;
  logic            grant;

  ycr2_rr_pick #(.TREQ(TREQ), .GW(GW)) u_pick (
    .req  (req),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

`ifdef YCR2_SCHED_WDT_EN
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  assign wdt_sat = (state_q != SCH_IDLE) && (&wdt_cnt_q);
`else
  // Never true for a legal width; keeps the watchdog width referenced in this build.
  assign wdt_sat = (WDT_W < 0);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    gnt_vld_d = gnt_vld_q;
    busy_d    = busy_q;
    wdt_err_d = 1'b0;
    rearb     = 1'b0;
    grant     = 1'b0;

    case (state_q)
      SCH_IDLE: grant = pick_any;
      SCH_REQ: begin
        if (lack) begin
          rearb = 1'b1;
        end else if (req_ack) begin
          state_d = SCH_BURST;
        end else if (!req[gnt_q]) begin
          state_d   = SCH_IDLE;
          gnt_vld_d = 1'b0;
          busy_d    = 1'b0;
        end else if (wdt_sat) begin
          rearb     = 1'b1;
          wdt_err_d = 1'b1;
        end
      end
      SCH_BURST: begin
        if (lack) begin
          rearb = 1'b1;
        end else if (wdt_sat) begin
          rearb     = 1'b1;
          wdt_err_d = 1'b1;
        end
      end
      default: begin
        state_d   = SCH_IDLE;
        gnt_vld_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    // last_q already names the old owner, so it naturally ranks lowest here.
    if (rearb) begin
      if (pick_any) begin
        grant = 1'b1;
      end else begin
        state_d   = SCH_IDLE;
        gnt_vld_d = 1'b0;
        busy_d    = 1'b0;
      end
    end

    if (grant) begin
      state_d   = SCH_REQ;
      gnt_d     = pick_win;
      last_d    = pick_win;
      gnt_vld_d = 1'b1;
      busy_d    = 1'b1;
    end
  end

`ifdef YCR2_SCHED_WDT_EN
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (grant || req_ack) wdt_cnt_d = '0;
    else if (state_q != SCH_IDLE) wdt_cnt_d = wdt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wdt_cnt_q <= '0;
    else     wdt_cnt_q <= wdt_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCH_IDLE;
      gnt_q     <= '0;
      last_q    <= GW'(TREQ - 1);
      gnt_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      wdt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      gnt_vld_q <= gnt_vld_d;
      busy_q    <= busy_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_vld   = gnt_vld_q;
  assign busy      = busy_q;
  assign wdt_err   = wdt_err_q;
  assign dbg_state = state_q;

endmodule
